// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one 64-bit memory port between the instruction-fetch requester
//   and the load/store requester. Each access runs through
//   IDLE -> ACCESS -> (WAIT) -> DONE. Completion is signalled by a
//   one-cycle done pulse on the owning port.
//
//   Arbitration: the data port normally has priority. A streak counter
//   forces a fetch grant after MAX_STREAK consecutive data grants made
//   while a fetch was pending.
//
// Ports
//   clk, reset          rising-edge clock, synchronous active-low reset
//   i_req/i_addr        fetch request, 4-byte aligned byte address
//   i_rdata/i_done      fetched 32-bit word, completion pulse
//   d_req/d_we/d_addr   data request (1 = store), 8-byte aligned byte address
//   d_wdata             store data
//   d_rdata/d_done      load data, completion pulse
//   mem_addr/mem_wdata  word address and write data to the memory macro
//   mem_we/mem_rdata    write enable, read data from the macro
//   busy                high in every state except IDLE
//   owner               port of current/last transaction (0 fetch, 1 data)
module mem_port_arbiter #(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned RD_LAT     = 2,
  parameter int unsigned MAX_STREAK = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [31:0]       i_rdata,
  output logic              i_done,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [63:0]       d_wdata,
  output logic [63:0]       d_rdata,
  output logic              d_done,
  output logic [ADDR_W-4:0] mem_addr,
  output logic [63:0]       mem_wdata,
  output logic              mem_we,
  input  logic [63:0]       mem_rdata,
  output logic              busy,
  output logic              owner
);

  localparam int unsigned CNT_W = $clog2(RD_LAT + 1);
  localparam int unsigned STK_W = $clog2(MAX_STREAK + 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_WAIT,
    ST_DONE
  } state_t;

  state_t            state_q,     state_d;
  logic              port_q,      port_d;     // 0 = fetch, 1 = data
  logic              we_q,        we_d;
  logic              sel_hi_q,    sel_hi_d;   // fetch address bit 2
  logic [CNT_W-1:0]  cnt_q,       cnt_d;
  logic [STK_W-1:0]  streak_q,    streak_d;
  logic [31:0]       i_rdata_q,   i_rdata_d;
  logic              i_done_q,    i_done_d;
  logic [63:0]       d_rdata_q,   d_rdata_d;
  logic              d_done_q,    d_done_d;
  logic [ADDR_W-4:0] mem_addr_q,  mem_addr_d;
  logic [63:0]       mem_wdata_q, mem_wdata_d;
  logic              mem_we_q,    mem_we_d;
  logic              busy_q,      busy_d;
  logic              owner_q,     owner_d;

  logic              streak_full;
  logic              grant_data;
  logic              grant_fetch;

  assign streak_full = (streak_q == STK_W'(MAX_STREAK));
  assign grant_data  = d_req && !(i_req && streak_full);
  assign grant_fetch = i_req && !grant_data;

  always_comb begin
    state_d     = state_q;
    port_d      = port_q;
    we_d        = we_q;
    sel_hi_d    = sel_hi_q;
    cnt_d       = cnt_q;
    streak_d    = streak_q;
    i_rdata_d   = i_rdata_q;
    i_done_d    = 1'b0;
    d_rdata_d   = d_rdata_q;
    d_done_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_we_d    = 1'b0;
    owner_d     = owner_q;

    // Memory-facing outputs are registered, so they are loaded at the grant
    // edge and are therefore presented during the ACCESS cycle.
    case (state_q)
      ST_IDLE: begin
        if (grant_data) begin
          state_d     = ST_ACCESS;
          port_d      = 1'b1;
          we_d        = d_we;
          sel_hi_d    = 1'b0;
          owner_d     = 1'b1;
          mem_addr_d  = d_addr[ADDR_W-1:3];
          mem_wdata_d = d_wdata;
          mem_we_d    = d_we;
          if (i_req && !streak_full) begin
            streak_d = streak_q + STK_W'(1);
          end
        end else if (grant_fetch) begin
          state_d    = ST_ACCESS;
          port_d     = 1'b0;
          we_d       = 1'b0;
          sel_hi_d   = i_addr[2];
          owner_d    = 1'b0;
          mem_addr_d = i_addr[ADDR_W-1:3];
          streak_d   = '0;
        end
      end

      ST_ACCESS: begin
        cnt_d = CNT_W'(RD_LAT);
        if (we_q) begin
          state_d  = ST_DONE;
          d_done_d = 1'b1;
        end else begin
          state_d = ST_WAIT;
        end
      end

      ST_WAIT: begin
        // Read data is valid in the last WAIT cycle; capture it on the edge
        // into DONE so the done pulse and the data appear together.
        if (cnt_q == CNT_W'(1)) begin
          state_d = ST_DONE;
          if (port_q) begin
            d_done_d  = 1'b1;
            d_rdata_d = mem_rdata;
          end else begin
            i_done_d  = 1'b1;
            i_rdata_d = sel_hi_q ? mem_rdata[63:32] : mem_rdata[31:0];
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      port_q      <= 1'b0;
      we_q        <= 1'b0;
      sel_hi_q    <= 1'b0;
      cnt_q       <= '0;
      streak_q    <= '0;
      i_rdata_q   <= '0;
      i_done_q    <= 1'b0;
      d_rdata_q   <= '0;
      d_done_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_we_q    <= 1'b0;
      busy_q      <= 1'b0;
      owner_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      port_q      <= port_d;
      we_q        <= we_d;
      sel_hi_q    <= sel_hi_d;
      cnt_q       <= cnt_d;
      streak_q    <= streak_d;
      i_rdata_q   <= i_rdata_d;
      i_done_q    <= i_done_d;
      d_rdata_q   <= d_rdata_d;
      d_done_q    <= d_done_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_we_q    <= mem_we_d;
      busy_q      <= busy_d;
      owner_q     <= owner_d;
    end
  end

  assign i_rdata   = i_rdata_q;
  assign i_done    = i_done_q;
  assign d_rdata   = d_rdata_q;
  assign d_done    = d_done_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_we    = mem_we_q;
  assign busy      = busy_q;
  assign owner     = owner_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
//   Directed bench for mem_port_arbiter with RD_LAT=2, MAX_STREAK=2.
//   The memory macro is modelled as an array with an RD_LAT-deep read
//   pipeline, so read data is only correct RD_LAT cycles after ACCESS.
module tb_mem_port_arbiter;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned RD_LAT = 2;

  logic              clk;
  logic              reset;
  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic [31:0]       i_rdata;
  logic              i_done;
  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [63:0]       d_wdata;
  logic [63:0]       d_rdata;
  logic              d_done;
  logic [ADDR_W-4:0] mem_addr;
  logic [63:0]       mem_wdata;
  logic              mem_we;
  logic [63:0]       mem_rdata;
  logic              busy;
  logic              owner;

  mem_port_arbiter #(
    .ADDR_W    (ADDR_W),
    .RD_LAT    (RD_LAT),
    .MAX_STREAK(2)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .i_req    (i_req),
    .i_addr   (i_addr),
    .i_rdata  (i_rdata),
    .i_done   (i_done),
    .d_req    (d_req),
    .d_we     (d_we),
    .d_addr   (d_addr),
    .d_wdata  (d_wdata),
    .d_rdata  (d_rdata),
    .d_done   (d_done),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_we   (mem_we),
    .mem_rdata(mem_rdata),
    .busy     (busy),
    .owner    (owner)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory macro model
  logic [63:0] mem   [0:63];
  logic [63:0] rpipe [0:RD_LAT-1];

  always @(posedge clk) begin
    if (mem_we) mem[mem_addr[5:0]] <= mem_wdata;
    rpipe[0] <= mem[mem_addr[5:0]];
    for (int k = 1; k < RD_LAT; k++) rpipe[k] <= rpipe[k-1];
  end
  assign mem_rdata = rpipe[RD_LAT-1];

  int checks   = 0;
  int failures = 0;

  logic [31:0] model_i;
  logic [63:0] model_d;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    bit          is_d;
    bit          we;
    logic [31:0] addr;
    logic [63:0] wdata;
    logic [63:0] exp_rd;
    int          lat;
  } vec_t;

  // Runs one isolated transaction. Starts and ends 1 time unit after a
  // rising edge with the DUT in IDLE; cycle 0 is the IDLE grant cycle.
  task automatic do_txn(input string name, input vec_t v);
    int          cyc;
    int          we_cnt;
    int          we_cyc;
    logic [28:0] we_addr;
    int          other_done;
    bit          got;
    cyc = 0; we_cnt = 0; we_cyc = -1; we_addr = '0; other_done = 0; got = 0;
    if (v.is_d) begin
      d_req = 1'b1; d_we = v.we; d_addr = v.addr; d_wdata = v.wdata;
    end else begin
      i_req = 1'b1; i_addr = v.addr;
    end
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (mem_we) begin we_cnt++; we_cyc = c; we_addr = mem_addr; end
      if (v.is_d ? i_done : d_done) other_done++;
      if (v.is_d ? d_done : i_done) begin cyc = c; got = 1; break; end
      @(posedge clk); #1;
    end
    checks++;
    if (!got) begin
      failures++;
      $display("FAIL %s_timeout actual=no_done required=done", name);
    end
    check({name, "_lat"}, 64'(cyc), 64'(v.lat));
    check({name, "_owner"}, {63'd0, owner}, {63'd0, v.is_d});
    check({name, "_busy_done"}, {63'd0, busy}, 64'd1);
    check({name, "_other_done"}, 64'(other_done), 64'd0);
    if (v.is_d && !v.we) model_d = v.exp_rd;
    if (!v.is_d) model_i = v.exp_rd[31:0];
    check({name, "_d_rdata"}, d_rdata, model_d);
    check({name, "_i_rdata"}, {32'd0, i_rdata}, {32'd0, model_i});
    if (v.is_d && v.we) begin
      check({name, "_we_cnt"}, 64'(we_cnt), 64'd1);
      check({name, "_we_cyc"}, 64'(we_cyc), 64'd1);
      check({name, "_we_addr"}, {35'd0, we_addr}, {35'd0, v.addr[31:3]});
    end else begin
      check({name, "_we_cnt"}, 64'(we_cnt), 64'd0);
    end
    @(posedge clk); #1;
    i_req = 1'b0; d_req = 1'b0;
    @(negedge clk);
    check({name, "_idle_busy"}, {63'd0, busy}, 64'd0);
    check({name, "_pulse_width"}, {62'd0, i_done, d_done}, 64'd0);
    @(posedge clk); #1;
  endtask

  vec_t vecs [8];

  initial begin
    int  dcyc, icyc, k;
    bit  drop;
    int  exp_port [6];
    logic own1, own6;

    for (int a = 0; a < 64; a++) mem[a] = 64'd0;
    mem[4] = 64'h11112222_33334444;
    for (int a = 0; a < RD_LAT; a++) rpipe[a] = 64'd0;

    vecs[0] = '{0, 0, 32'h24, 64'd0, 64'h0000_0000_1111_2222, 4};
    vecs[1] = '{0, 0, 32'h20, 64'd0, 64'h0000_0000_3333_4444, 4};
    vecs[2] = '{1, 1, 32'h40, 64'hDEADBEEF_CAFEF00D, 64'd0, 2};
    vecs[3] = '{1, 0, 32'h40, 64'd0, 64'hDEADBEEF_CAFEF00D, 4};
    vecs[4] = '{0, 0, 32'h44, 64'd0, 64'h0000_0000_DEAD_BEEF, 4};
    vecs[5] = '{1, 1, 32'h48, 64'h01234567_89ABCDEF, 64'd0, 2};
    vecs[6] = '{1, 0, 32'h4F, 64'd0, 64'h01234567_89ABCDEF, 4};
    vecs[7] = '{0, 0, 32'h4C, 64'd0, 64'h0000_0000_0123_4567, 4};

    reset = 1'b0; i_req = 1'b0; i_addr = '0;
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
    model_i = '0; model_d = '0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_owner", {63'd0, owner}, 64'd0);
    check("rst_done", {62'd0, i_done, d_done}, 64'd0);
    check("rst_mem_we", {63'd0, mem_we}, 64'd0);
    check("rst_i_rdata", {32'd0, i_rdata}, 64'd0);
    check("rst_d_rdata", d_rdata, 64'd0);
    check("rst_mem_addr", {35'd0, mem_addr}, 64'd0);
    check("rst_mem_wdata", mem_wdata, 64'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;

    for (int n = 0; n < 8; n++) do_txn($sformatf("vec%0d", n), vecs[n]);

    // Simultaneous requests: data first, fetch in the IDLE cycle after d_done.
    i_req = 1'b1; i_addr = 32'h24;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h40;
    dcyc = -1; icyc = -1; own1 = 1'b0; own6 = 1'b1;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (c == 1) own1 = owner;
      if (c == 6) own6 = owner;
      if (d_done && dcyc < 0) dcyc = c;
      if (i_done && icyc < 0) icyc = c;
      @(posedge clk); #1;
      if (dcyc == c) d_req = 1'b0;
      if (icyc == c) begin i_req = 1'b0; break; end
    end
    check("both_d_cycle", 64'(dcyc), 64'd4);
    check("both_i_cycle", 64'(icyc), 64'd9);
    check("both_owner_data", {63'd0, own1}, 64'd1);
    check("both_owner_fetch", {63'd0, own6}, 64'd0);
    check("both_d_rdata", d_rdata, 64'hDEADBEEF_CAFEF00D);
    check("both_i_rdata", {32'd0, i_rdata}, 64'h1111_2222);
    @(posedge clk); #1;

    // Streak limit 2 with both requesters continuously asking.
    exp_port = '{1, 1, 0, 1, 1, 0};
    i_req = 1'b1; i_addr = 32'h20;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h48;
    k = 0; drop = 0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (d_done || i_done) begin
        check($sformatf("streak_port%0d", k), {63'd0, d_done}, 64'(exp_port[k]));
        check($sformatf("streak_cyc%0d", k), 64'(c), 64'(4 + 5 * k));
        k++;
        if (k == 6) drop = 1;
      end
      @(posedge clk); #1;
      if (drop) begin i_req = 1'b0; d_req = 1'b0; break; end
    end
    check("streak_count", 64'(k), 64'd6);
    check("streak_d_rdata", d_rdata, 64'h01234567_89ABCDEF);
    check("streak_i_rdata", {32'd0, i_rdata}, 64'h3333_4444);
    @(posedge clk); #1;

    // Reset during WAIT of a load drops the transaction.
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h40;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk);
    check("rstw_busy_wait", {63'd0, busy}, 64'd1);
    reset = 1'b0; d_req = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    check("rstw_busy", {63'd0, busy}, 64'd0);
    check("rstw_d_done", {63'd0, d_done}, 64'd0);
    check("rstw_d_rdata", d_rdata, 64'd0);
    check("rstw_i_rdata", {32'd0, i_rdata}, 64'd0);
    check("rstw_mem_we", {63'd0, mem_we}, 64'd0);
    check("rstw_mem_addr", {35'd0, mem_addr}, 64'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    dcyc = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (d_done || i_done || busy) dcyc++;
      @(posedge clk); #1;
    end
    check("rstw_no_activity", 64'(dcyc), 64'd0);
    model_i = '0; model_d = '0;
    do_txn("post_rst_fetch", '{0, 0, 32'h20, 64'd0, 64'h0000_0000_3333_4444, 4});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single on-chip memory port between the instruction-fetch requester and the load/store requester of the multicycle core.
- Sequences each access through a fixed-latency FSM and returns read data on a per-port done pulse.
- Sits between the control/processing blocks and the memory macro, replacing separate instruction and data memories.
- Data has priority; a streak counter guarantees that fetch is not starved.

Parameters:
ADDR_W, 32, byte-address width of both requester ports
RD_LAT, 2, memory read latency in cycles (>=1); mem_rdata is valid RD_LAT cycles after the ACCESS cycle
MAX_STREAK, 3, consecutive data grants allowed while i_req is pending before fetch is forced

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-low reset
i_req  in  1  fetch request; held with i_addr stable until i_done
i_addr  in  ADDR_W  fetch byte address, 4-byte aligned
i_rdata  out  32  fetched instruction
i_done  out  1  one-cycle completion pulse for fetch
d_req  in  1  data request; held with d_we/d_addr/d_wdata stable until d_done
d_we  in  1  1 = store, 0 = load
d_addr  in  ADDR_W  data byte address, 8-byte aligned; d_addr[2:0] ignored
d_wdata  in  64  store data
d_rdata  out  64  load data
d_done  out  1  one-cycle completion pulse for data
mem_addr  out  ADDR_W-3  word address to memory
mem_wdata  out  64  write data to memory
mem_we  out  1  memory write enable
mem_rdata  in  64  memory read data
busy  out  1  high in every state except IDLE
owner  out  1  port of the current or last transaction: 0 = fetch, 1 = data

Behaviour:
- States: IDLE, ACCESS, WAIT, DONE.
- Reset (reset==0 at a clock edge) applies in any state. Next state is IDLE; every output is 0; streak counter is 0; mem_we is 0 in the cycle after reset is sampled. An in-flight transaction is dropped with no done pulse.
- IDLE arbitration:
  - Only one request pending: grant it.
  - Both pending: grant data, unless streak==MAX_STREAK, then grant fetch.
  - On grant, latch the port, address, we and wdata, then go to ACCESS.
  - No request: stay in IDLE.
- Streak counter: increments (saturating at MAX_STREAK) on each data grant made while i_req=1; clears on each fetch grant; unchanged on a data grant with i_req=0.
- ACCESS, one cycle:
  - mem_addr = latched addr[ADDR_W-1:3].
  - mem_we = latched we.
  - mem_wdata = latched wdata.
  - Store: go to DONE. Load or fetch: load a counter with RD_LAT and go to WAIT.
- WAIT: mem_addr is held and mem_we=0. The counter decrements each cycle; when it reaches 1, go to DONE.
- DONE, one cycle:
  - Fetch: i_done=1 and i_rdata = addr[2] ? mem_rdata[63:32] : mem_rdata[31:0].
  - Load: d_done=1 and d_rdata = mem_rdata.
  - Store: d_done=1 and d_rdata is unchanged.
  - Then go to IDLE.
- i_rdata and d_rdata are registered and hold their value until the next completion on the same port.
- Latency, counting the IDLE grant cycle as cycle 0: fetch and load done at cycle RD_LAT+2; store done at cycle 2.
- There is always at least one IDLE cycle between transactions.
- Requesters drop req at the edge that ends DONE. A req still high in IDLE is treated as a new request.
- mem_we is high only in ACCESS with we=1, and never on fetch.
- mem_addr and mem_wdata hold their last values outside ACCESS/WAIT.
- owner updates at grant.

Test Plan:
- Fetch alone, RD_LAT=2, mem[4]=0x11112222_33334444. i_addr=0x24 -> i_done at cycle 4, i_rdata=0x11112222. i_addr=0x20 -> i_rdata=0x33334444. mem_we stays 0 throughout.
- Data store then load. Store d_addr=0x40, d_wdata=0xDEADBEEF_CAFEF00D -> mem_we=1 in cycle 1 only, mem_addr=8, d_done at cycle 2. Load from 0x40 -> d_done at cycle 4, d_rdata=0xDEADBEEF_CAFEF00D.
- i_req and d_req rise in the same cycle -> data served first (owner=1). Fetch is granted in the IDLE cycle after d_done; i_done follows 4 cycles later.
- MAX_STREAK=2, i_req held, back-to-back data loads -> grant order D, D, I, D. Streak is 0 after the fetch grant.
- reset=0 during WAIT of a load -> next cycle busy=0, no d_done, d_rdata=0, mem_we=0. A new fetch then completes normally.
- After a load, d_rdata holds its value through a following fetch, and i_rdata holds its value through a following store.
